// File: rtl/mem_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_scheduler_if
// Description : CPU data-port bundle between a CPU (master) and the memory
//               access scheduler (slave).
//               master: drives cpu_req/cpu_we/cpu_addr/cpu_wdata,
//                       receives cpu_gnt/cpu_rdata/cpu_rvalid/cpu_err
//               slave : the mirror image
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_scheduler_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [14:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_gnt;
    logic [15:0] cpu_rdata;
    logic        cpu_rvalid;
    logic        cpu_err;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rdata, cpu_rvalid, cpu_err
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rdata, cpu_rvalid, cpu_err
    );
endinterface
`default_nettype wire

// File: rtl/mem_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : mem_scheduler
// Description : Shares the single Hack Memory port between the CPU data port
//               and a screen scan-out engine that fetches one row per burst.
//               CPU writes at or above 0x6000 are granted but dropped.
// Ports       : clk, rst_n (async, active low)
//               cpu        - mem_scheduler_if.slave (req/we/addr/wdata in,
//                            gnt/rdata/rvalid/err out)
//               vid_start, vid_row in; vid_busy, vid_data, vid_valid,
//               vid_word, vid_done out
//               mem_addr, mem_in, mem_load out; mem_out in
// Options     : MEM_SCHED_VIDEO_PRIO_EN - video wins every contended slot
//               during a burst (default: round-robin)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_scheduler #(
    parameter int WORDS_PER_ROW = 32,
    parameter int ROW_W         = 8
) (
    input  wire logic                             clk,
    input  wire logic                             rst_n,
    mem_scheduler_if.slave                        cpu,
    input  wire logic                             vid_start,
    input  wire logic [ROW_W-1:0]                 vid_row,
    output logic                                  vid_busy,
    output logic [15:0]                           vid_data,
    output logic                                  vid_valid,
    output logic [$clog2(WORDS_PER_ROW)-1:0]      vid_word,
    output logic                                  vid_done,
    output logic [14:0]                           mem_addr,
    output logic [15:0]                           mem_in,
    output logic                                  mem_load,
    input  wire logic [15:0]                      mem_out
);

    localparam int          CNT_W         = $clog2(WORDS_PER_ROW);
    localparam logic [14:0] c_screen_base = 15'h4000;
    localparam logic [14:0] c_kbd_base    = 15'h6000;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ROW_W-1:0]  r_row;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_last_vid;   // 1: video owned the most recent burst slot
    logic [15:0]       r_cpu_rdata;
    logic              r_cpu_rvalid;
    logic              r_cpu_err;
    logic [15:0]       r_vid_data;
    logic [CNT_W-1:0]  r_vid_word;
    logic              r_vid_valid;
    logic              r_vid_done;

    logic              w_cpu_gnt;
    logic              w_vid_slot;
    logic              w_busy;
    logic              w_start;
    logic              w_last_word;
    logic              w_cpu_blocked;
    logic [14:0]       w_vid_addr;

    // Busy stays up through the final vid_valid/vid_done beat so a new start
    // cannot overlap the tail of the previous burst.
    assign w_busy        = (r_state == ST_BURST) | r_vid_done;
    assign w_start       = vid_start & ~w_busy;
    assign w_last_word   = (r_cnt == CNT_W'(WORDS_PER_ROW - 1));
    assign w_cpu_blocked = (cpu.cpu_addr >= c_kbd_base);
    // Row/word concatenation equals row*WORDS_PER_ROW + cnt (power-of-two row).
    assign w_vid_addr    = c_screen_base + 15'({r_row, r_cnt});

    always_comb begin
        w_state_nxt = r_state;
        w_cpu_gnt   = 1'b0;
        w_vid_slot  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Gating with rst_n keeps every output low while in reset.
                w_cpu_gnt = cpu.cpu_req & rst_n;
                if (w_start) begin
                    w_state_nxt = ST_BURST;
                end
            end
            ST_BURST: begin
`ifdef MEM_SCHED_VIDEO_PRIO_EN
                w_vid_slot = 1'b1;
`else
                if (cpu.cpu_req && r_last_vid) begin
                    w_cpu_gnt = 1'b1;
                end else begin
                    w_vid_slot = 1'b1;
                end
`endif
                if (w_vid_slot && w_last_word) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_addr = 15'd0;
        mem_in   = 16'd0;
        mem_load = 1'b0;
        if (w_cpu_gnt) begin
            mem_addr = cpu.cpu_addr;
            mem_in   = cpu.cpu_wdata;
            mem_load = cpu.cpu_we & ~w_cpu_blocked;
        end else if (w_vid_slot) begin
            mem_addr = w_vid_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_row        <= '0;
            r_cnt        <= '0;
            r_last_vid   <= 1'b1;
            r_cpu_rdata  <= 16'd0;
            r_cpu_rvalid <= 1'b0;
            r_cpu_err    <= 1'b0;
            r_vid_data   <= 16'd0;
            r_vid_word   <= '0;
            r_vid_valid  <= 1'b0;
            r_vid_done   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_row <= vid_row;
                r_cnt <= '0;
            end else if (w_vid_slot) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            // Exactly one side owns every burst cycle, so the flag simply
            // records whether that owner was video.
            if (r_state == ST_BURST) begin
                r_last_vid <= w_vid_slot;
            end
            r_cpu_rvalid <= w_cpu_gnt & ~cpu.cpu_we;
            if (w_cpu_gnt && !cpu.cpu_we) begin
                r_cpu_rdata <= mem_out;
            end
            r_cpu_err   <= w_cpu_gnt & cpu.cpu_we & w_cpu_blocked;
            r_vid_valid <= w_vid_slot;
            if (w_vid_slot) begin
                r_vid_data <= mem_out;
                r_vid_word <= r_cnt;
            end
            r_vid_done <= w_vid_slot & w_last_word;
        end
    end

    assign cpu.cpu_gnt    = w_cpu_gnt;
    assign cpu.cpu_rdata  = r_cpu_rdata;
    assign cpu.cpu_rvalid = r_cpu_rvalid;
    assign cpu.cpu_err    = r_cpu_err;
    assign vid_busy       = w_busy;
    assign vid_data       = r_vid_data;
    assign vid_word       = r_vid_word;
    assign vid_valid      = r_vid_valid;
    assign vid_done       = r_vid_done;

endmodule
`default_nettype wire
